piso_read_sched: RTL and testbench

Read scheduler and round-robin arbiter sitting between a single-port SRAM and the 32-bit parallel-in/serial-out serializer. Up to N_REQ requesters each ask for a burst of consecutive SRAM words. The block grants one requester at a time, fetches each word from the SRAM and hands it to the serializer with a one-cycle load strobe. It waits for the serializer to finish shifting before fetching the next word, then signals burst completion to the owner.

---
 rtl/piso_read_sched_if.sv | 47 ++++
 rtl/piso_read_sched.sv | 166 ++++++++++++++++
 tb/tb_piso_read_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_read_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_read_sched_if
// Purpose  : Bundles the requester, SRAM and serializer signals of the
//            piso_read_sched block.
//            slave  - the scheduler side (drives grant/done/SRAM/serializer)
//            master - the environment side (requesters, SRAM, serializer)
// Signals  : req/req_addr/req_len    requester inputs (slice i = requester i)
//            grant/done              one-cycle per-requester pulses
//            busy/cur_id             scheduler status
//            sram_cs/sram_addr       SRAM read port, sram_rdata one cycle later
//            ser_rd_en/ser_data      serializer load strobe and word
//            ser_read_ready          serializer idle/ready
// Revision : 1.0 - initial release
// ============================================================================
interface piso_read_sched_if #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 2
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    busy;
  logic [ID_W-1:0]         cur_id;
  logic                    sram_cs;
  logic [ADDR_W-1:0]       sram_addr;
  logic [WIDTH-1:0]        sram_rdata;
  logic                    ser_rd_en;
  logic [WIDTH-1:0]        ser_data;
  logic                    ser_read_ready;

  modport slave (
    input  req, req_addr, req_len, sram_rdata, ser_read_ready,
    output grant, done, busy, cur_id, sram_cs, sram_addr, ser_rd_en, ser_data
  );

  modport master (
    output req, req_addr, req_len, sram_rdata, ser_read_ready,
    input  grant, done, busy, cur_id, sram_cs, sram_addr, ser_rd_en, ser_data
  );
endinterface
`default_nettype wire

// File: rtl/piso_read_sched.sv
`default_nettype none
// ============================================================================
// Module   : piso_read_sched
// Purpose  : Round-robin read scheduler between a single-port SRAM and a
//            parallel-in/serial-out serializer. The granted requester's burst
//            is fetched one word at a time; each word is handed to the
//            serializer with a one-cycle load strobe, and the next word is
//            fetched only after the serializer reports ready again.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - piso_read_sched_if.slave (requester, SRAM, serializer)
// Revision : 1.0 - initial release
// ============================================================================
module piso_read_sched #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  piso_read_sched_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAP   = 3'd2,
    S_LOAD  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_cur_id;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [LEN_W-1:0]   r_rem;
  logic [WIDTH-1:0]   r_word;
  logic [N_REQ-1:0]   r_grant;

  logic               w_found;
  logic               w_found_hi;
  logic [ID_W-1:0]    w_lo_id;
  logic [ID_W-1:0]    w_hi_id;
  logic [ID_W-1:0]    w_win;
  logic [N_REQ-1:0]   w_win_oh;
  logic [N_REQ-1:0]   w_cur_oh;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [LEN_W-1:0]   w_win_len;
  logic [ID_W-1:0]    w_rr_nxt;

  // Round-robin pick: the lowest requester at or above r_rr_ptr wins; if none
  // is there, wrap around to the lowest requester overall. Scanning downward
  // leaves the lowest matching index in each candidate.
  always_comb begin
    w_found    = 1'b0;
    w_found_hi = 1'b0;
    w_lo_id    = '0;
    w_hi_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_found = 1'b1;
        w_lo_id = ID_W'(i);
        if (ID_W'(i) >= r_rr_ptr) begin
          w_found_hi = 1'b1;
          w_hi_id    = ID_W'(i);
        end
      end
    end
    w_win = w_found_hi ? w_hi_id : w_lo_id;
  end

  always_comb begin
    w_win_oh   = '0;
    w_cur_oh   = '0;
    w_win_addr = '0;
    w_win_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_win_oh[i] = (w_win == ID_W'(i));
      w_cur_oh[i] = (r_cur_id == ID_W'(i));
      if (w_win == ID_W'(i)) begin
        w_win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_win_len  = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign w_rr_nxt = (r_cur_id == ID_W'(N_REQ - 1)) ? '0 : r_cur_id + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A zero-length burst still spends its grant cycle in RD (with the SRAM read
  // suppressed) so that grant, done and the return to IDLE land on
  // consecutive cycles exactly as for a normal burst's first slot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_RD;
      S_RD:    w_state_nxt = (r_rem == '0) ? S_DONE : S_CAP;
      S_CAP:   w_state_nxt = S_LOAD;
      S_LOAD:  if (bus.ser_read_ready) w_state_nxt = S_DRAIN;
      S_DRAIN: if (bus.ser_read_ready)
                 w_state_nxt = (r_rem == LEN_W'(1)) ? S_DONE : S_RD;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_cur_id   <= '0;
      r_cur_addr <= '0;
      r_rem      <= '0;
      r_word     <= '0;
      r_grant    <= '0;
    end else begin
      r_grant <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_cur_id   <= w_win;
            r_cur_addr <= w_win_addr;
            r_rem      <= w_win_len;
            r_grant    <= w_win_oh;
          end
        end
        S_CAP: begin
          r_word <= bus.sram_rdata;
        end
        S_DRAIN: begin
          // Serializer has finished the previous word: advance the burst.
          if (bus.ser_read_ready) begin
            r_rem      <= r_rem - LEN_W'(1);
            r_cur_addr <= r_cur_addr + ADDR_W'(1);
          end
        end
        S_DONE: begin
          r_rr_ptr <= w_rr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = (r_state == S_DONE) ? w_cur_oh : '0;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.cur_id    = r_cur_id;
  assign bus.sram_cs   = (r_state == S_RD) && (r_rem != '0);
  assign bus.sram_addr = r_cur_addr;
  assign bus.ser_rd_en = (r_state == S_LOAD) && bus.ser_read_ready;
  assign bus.ser_data  = r_word;

endmodule
`default_nettype wire

// File: tb/tb_piso_read_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_read_sched
// Purpose  : Self-checking bench for piso_read_sched. Models the SRAM
//            (word[a] = 0xA5A50000 | a) and a serializer that stays busy for
//            32 cycles after each load; expected SRAM addresses and load words
//            are queued when a request is driven and popped on DUT activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_read_sched;
  localparam int N_REQ  = 4;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;
  localparam int ID_W   = 2;

  logic clk;
  logic rst;
  logic ser_hold;
  int   cyc = 0;
  int   ser_cnt;
  int   errors = 0;
  int   checks = 0;
  logic prev_busy;

  logic [WIDTH-1:0]  exp_load[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int g_id_q[$], g_cyc_q[$], d_id_q[$], d_cyc_q[$], l_cyc_q[$], bf_q[$], cs_q[$];

  piso_read_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W),
                       .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

  piso_read_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W),
                    .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: registered read, data valid the cycle after sram_cs.
  always @(posedge clk) begin
    if (bus.sram_cs) bus.sram_rdata <= 32'hA5A5_0000 | 32'(bus.sram_addr);
  end

  // Serializer: ready drops the cycle after a load and returns 32 cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst)                ser_cnt <= 0;
    else if (bus.ser_rd_en) ser_cnt <= 32;
    else if (ser_cnt != 0)  ser_cnt <= ser_cnt - 1;
  end
  assign bus.ser_read_ready = (ser_cnt == 0) && !ser_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] word_of(input logic [ADDR_W-1:0] a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  task automatic expect_word(input logic [ADDR_W-1:0] a);
    exp_addr.push_back(a);
    exp_load.push_back(word_of(a));
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_len[i*LEN_W +: LEN_W]    = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_id_q.delete(); g_cyc_q.delete(); d_id_q.delete(); d_cyc_q.delete();
    l_cyc_q.delete(); bf_q.delete(); cs_q.delete();
  endtask

  task automatic wait_grants(input int n, input string tag);
    for (int i = 0; i < 2000 && g_cyc_q.size() < n; i++) step();
    chk(tag, g_cyc_q.size(), n);
  endtask

  task automatic wait_dones(input int n, input string tag);
    for (int i = 0; i < 2000 && d_cyc_q.size() < n; i++) step();
    chk(tag, d_cyc_q.size(), n);
  endtask

  task automatic wait_loads(input int n, input string tag);
    for (int i = 0; i < 2000 && l_cyc_q.size() < n; i++) step();
    chk(tag, l_cyc_q.size(), n);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_grant"},     bus.grant, 0);
    chk({pfx, "_done"},      bus.done, 0);
    chk({pfx, "_busy"},      bus.busy, 0);
    chk({pfx, "_cur_id"},    bus.cur_id, 0);
    chk({pfx, "_sram_cs"},   bus.sram_cs, 0);
    chk({pfx, "_sram_addr"}, bus.sram_addr, 0);
    chk({pfx, "_ser_rd_en"}, bus.ser_rd_en, 0);
    chk({pfx, "_ser_data"},  bus.ser_data, 0);
  endtask

  // Monitor: scoreboard pops and event logging, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ser_rd_en) begin
        l_cyc_q.push_back(cyc);
        chk("load_expected", exp_load.size() != 0, 1'b1);
        if (exp_load.size() != 0) chk("load_data", bus.ser_data, exp_load.pop_front());
      end
      if (bus.sram_cs) begin
        cs_q.push_back(cyc);
        chk("sram_expected", exp_addr.size() != 0, 1'b1);
        if (exp_addr.size() != 0) chk("sram_addr", bus.sram_addr, exp_addr.pop_front());
      end
      if (bus.grant != '0) begin
        chk("grant_onehot", $onehot(bus.grant), 1'b1);
        for (int i = 0; i < N_REQ; i++) if (bus.grant[i]) g_id_q.push_back(i);
        g_cyc_q.push_back(cyc);
      end
      if (bus.done != '0) begin
        chk("done_onehot", $onehot(bus.done), 1'b1);
        for (int i = 0; i < N_REQ; i++) if (bus.done[i]) d_id_q.push_back(i);
        d_cyc_q.push_back(cyc);
      end
      if (prev_busy && !bus.busy) bf_q.push_back(cyc);
    end
    prev_busy <= rst ? 1'b0 : bus.busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int ord[5];
    ord = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    ser_hold = 1'b0;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    repeat (3) step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    repeat (2) step();

    // Contention: all four requesters held, one word each.
    clear_logs();
    for (int i = 0; i < N_REQ; i++) set_req(i, 8'h20 + 8'(4 * i), 8'd1);
    for (int k = 0; k < 5; k++) expect_word(8'h20 + 8'(4 * ord[k]));
    t = cyc;
    bus.req = 4'b1111;
    wait_grants(5, "cont_grant_count");
    bus.req = '0;
    wait_dones(5, "cont_done_count");
    chk("cont_first_grant_cyc", g_cyc_q[0], t + 1);
    for (int k = 0; k < 5; k++) chk("cont_grant_order", g_id_q[k], ord[k]);
    for (int k = 1; k < 5; k++) chk("cont_grant_after_done", g_cyc_q[k], d_cyc_q[k-1] + 2);
    repeat (4) step();

    // Single burst of three words from requester 0.
    clear_logs();
    set_req(0, 8'h10, 8'd3);
    expect_word(8'h10); expect_word(8'h11); expect_word(8'h12);
    t = cyc;
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    wait_dones(1, "single_done_seen");
    repeat (40) step();
    chk("single_grant_id", g_id_q[0], 0);
    chk("single_grant_cyc", g_cyc_q[0], t + 1);
    chk("single_load0_cyc", l_cyc_q[0], t + 3);
    chk("single_load1_cyc", l_cyc_q[1], t + 39);
    chk("single_load2_cyc", l_cyc_q[2], t + 75);
    chk("single_done_id", d_id_q[0], 0);
    chk("single_done_cyc", d_cyc_q[0], t + 75 + 34);
    chk("single_busy_fall", bf_q[0], t + 75 + 35);
    chk("single_done_count", d_cyc_q.size(), 1);

    // Address wrap 0xFE, 0xFF, 0x00 from requester 3.
    clear_logs();
    set_req(3, 8'hFE, 8'd3);
    expect_word(8'hFE); expect_word(8'hFF); expect_word(8'h00);
    t = cyc;
    bus.req = 4'b1000;
    step();
    bus.req = '0;
    wait_dones(1, "wrap_done_seen");
    repeat (3) step();
    chk("wrap_grant_id", g_id_q[0], 3);
    chk("wrap_done_id", d_id_q[0], 3);
    chk("wrap_sram_reads", cs_q.size(), 3);

    // Zero-length request from requester 2.
    clear_logs();
    set_req(2, 8'h33, 8'd0);
    t = cyc;
    bus.req = 4'b0100;
    step();
    bus.req = '0;
    repeat (5) step();
    chk("len0_grant_id", g_id_q[0], 2);
    chk("len0_grant_cyc", g_cyc_q[0], t + 1);
    chk("len0_done_id", d_id_q[0], 2);
    chk("len0_done_cyc", d_cyc_q[0], t + 2);
    chk("len0_busy_fall", bf_q[0], t + 3);
    chk("len0_no_sram", cs_q.size(), 0);
    chk("len0_no_load", l_cyc_q.size(), 0);

    // Serializer stall for 10 cycles in LOAD.
    clear_logs();
    set_req(1, 8'h40, 8'd1);
    expect_word(8'h40);
    ser_hold = 1'b1;
    t = cyc;
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    repeat (2) step();
    for (int k = 0; k < 10; k++) begin
      chk("stall_no_strobe", bus.ser_rd_en, 1'b0);
      chk("stall_data", bus.ser_data, word_of(8'h40));
      chk("stall_busy", bus.busy, 1'b1);
      step();
    end
    ser_hold = 1'b0;
    wait_loads(1, "stall_load_seen");
    chk("stall_load_cyc", l_cyc_q[0], t + 13);
    wait_dones(1, "stall_done_seen");
    chk("stall_done_cyc", d_cyc_q[0], t + 13 + 34);
    repeat (3) step();

    // Reset asserted during DRAIN of word 2 of a four-word burst.
    clear_logs();
    set_req(0, 8'h80, 8'd4);
    expect_word(8'h80); expect_word(8'h81);
    t = cyc;
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    wait_loads(2, "mr_loads_seen");
    chk("mr_load1_cyc", l_cyc_q[1], t + 39);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk_reset_outputs("mr");
    repeat (2) step();
    rst = 1'b0;
    repeat (40) step();
    chk("mr_no_done", d_cyc_q.size(), 0);

    // New request after reset release.
    clear_logs();
    set_req(1, 8'h50, 8'd1);
    expect_word(8'h50);
    t = cyc;
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    wait_dones(1, "post_done_seen");
    chk("post_grant_id", g_id_q[0], 1);
    chk("post_grant_cyc", g_cyc_q[0], t + 1);
    chk("post_done_id", d_id_q[0], 1);
    repeat (3) step();

    chk("end_load_queue_empty", exp_load.size(), 0);
    chk("end_addr_queue_empty", exp_addr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
